// File: rtl/adc_sched_pkg.sv
// Shared constants, FSM encoding and helpers for the ADC scan scheduler.
// Imported by adc_scan_sched.
package adc_sched_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned ACC_W  = 15;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StCollect,
    StGuard,
    StPublish
  } sched_state_e;

  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [DATA_W-1:0] data_t;

  // Divide an accumulated sum by the number of scans and keep the result width.
  function automatic data_t avg_result(input acc_t acc, input logic [1:0] avg_log2);
    acc_t shifted;
    shifted = acc >> avg_log2;
    return shifted[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Free-running reload counter that produces one tick per frame period while enabled.
// Counts 0..period and ticks on the reload cycle; cleared whenever disabled.
module adc_period_timer #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_l,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick
);

  logic [PERIOD_W-1:0] r_cnt;
  logic                w_reload;

  // >= keeps the counter from running past a freshly shortened period.
  assign w_reload = i_enable && (r_cnt >= i_period);
  assign o_tick   = w_reload;

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_cnt <= '0;
    end else if (!i_enable || w_reload) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/adc_scan_sched.sv
// Scan scheduler for the 8-channel serial ADC engine: triggers scans, averages
// per-channel results over 1/2/4/8 scans and publishes whole frames to a read bank.
module adc_scan_sched
  import adc_sched_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned TIMEOUT  = 4096,
  parameter int unsigned GUARD    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_l,
  input  logic                i_enable,
  input  logic                i_single,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [NUM_CH-1:0]   i_ch_mask,
  input  logic [1:0]          i_avg_log2,
  input  logic                i_err_clr,
  output logic                o_adc_sync,
  input  logic                i_adc_rd_en,
  input  logic [CH_W-1:0]     i_adc_channel,
  input  logic [DATA_W-1:0]   i_adc_data,
  input  logic                i_rd_req,
  input  logic [CH_W-1:0]     i_rd_addr,
  output logic                o_rd_valid,
  output logic [DATA_W-1:0]   o_rd_data,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic [7:0]          o_seq,
  output logic                o_overrun,
  output logic                o_timeout_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned GD_W = $clog2(GUARD + 1);

  sched_state_e r_state;
  sched_state_e w_state_next;

  logic              w_tick;
  logic              w_trigger;
  logic              w_start;
  logic              w_timeout;
  logic              w_guard_done;
  logic              w_publish;
  logic              w_result;
  logic              w_last_ch;
  logic [2:0]        w_round_max;

  logic [NUM_CH-1:0] r_mask;
  logic [1:0]        r_avg;
  logic [2:0]        r_round;
  logic              r_abort;
  logic [TO_W-1:0]   r_to_cnt;
  logic [GD_W-1:0]   r_guard_cnt;

  logic              r_en_d1;
  logic              r_en_d2;
  logic [CH_W-1:0]   r_ch_d1;
  logic [DATA_W-1:0] r_data_d1;

  acc_t              r_acc  [NUM_CH];
  data_t             r_bank [NUM_CH];

  logic              r_sync;
  logic              r_frame_done;
  logic [7:0]        r_seq;
  logic              r_overrun;
  logic              r_timeout_err;
  logic              r_rd_valid;
  data_t             r_rd_data;

  adc_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_period_timer (
    .i_clk    (i_clk),
    .i_rst_l  (i_rst_l),
    .i_enable (i_enable),
    .i_period (i_period),
    .o_tick   (w_tick)
  );

  assign w_trigger   = (w_tick && i_enable) || i_single;
  // A result is the registered rising edge of the engine strobe.
  assign w_result    = r_en_d1 && !r_en_d2;
  assign w_last_ch   = (r_ch_d1 == CH_W'(NUM_CH - 1));
  assign w_round_max = 3'((4'd1 << r_avg) - 4'd1);

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_timeout    = 1'b0;
    w_guard_done = 1'b0;
    w_publish    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_trigger) begin
          w_start      = 1'b1;
          w_state_next = StSync;
        end
      end
      StSync: begin
        w_state_next = StCollect;
      end
      StCollect: begin
        if (w_result && w_last_ch) begin
          w_state_next = StGuard;
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = StGuard;
        end
      end
      StGuard: begin
        if (r_guard_cnt == GD_W'(GUARD - 1)) begin
          w_guard_done = 1'b1;
          if (r_abort) begin
            w_state_next = StIdle;
          end else if (r_round != w_round_max) begin
            w_state_next = StSync;
          end else begin
            w_state_next = StPublish;
          end
        end
      end
      StPublish: begin
        w_publish    = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Frame context, round and the two watchdog-style counters.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_mask      <= '0;
      r_avg       <= '0;
      r_round     <= '0;
      r_abort     <= 1'b0;
      r_to_cnt    <= '0;
      r_guard_cnt <= '0;
    end else begin
      if (w_start) begin
        r_mask  <= i_ch_mask;
        r_avg   <= i_avg_log2;
        r_round <= '0;
        r_abort <= 1'b0;
      end else begin
        if (w_timeout) begin
          r_abort <= 1'b1;
        end
        if (w_guard_done && (w_state_next == StSync)) begin
          r_round <= r_round + 3'd1;
        end
      end

      if (r_state == StSync) begin
        r_to_cnt <= '0;
      end else if (r_state == StCollect) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      if (r_state == StGuard) begin
        r_guard_cnt <= r_guard_cnt + GD_W'(1);
      end else begin
        r_guard_cnt <= '0;
      end
    end
  end

  // Data is captured every cycle so it lines up with the detected strobe edge.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_en_d1   <= 1'b0;
      r_en_d2   <= 1'b0;
      r_ch_d1   <= '0;
      r_data_d1 <= '0;
    end else begin
      r_en_d1   <= i_adc_rd_en;
      r_en_d2   <= r_en_d1;
      r_ch_d1   <= i_adc_channel;
      r_data_d1 <= i_adc_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i]  <= '0;
        r_bank[i] <= '0;
      end
    end else begin
      if (w_start) begin
        for (int i = 0; i < NUM_CH; i++) begin
          r_acc[i] <= '0;
        end
      end else if ((r_state == StCollect) && w_result) begin
        r_acc[r_ch_d1] <= r_acc[r_ch_d1] + ACC_W'(r_data_d1);
      end

      if (w_publish) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_mask[i]) begin
            r_bank[i] <= avg_result(r_acc[i], r_avg);
          end
        end
      end
    end
  end

  // Status flags and host read port; a sticky set beats a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_sync        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_seq         <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
    end else begin
      r_sync       <= (r_state == StSync);
      r_frame_done <= w_publish;
      if (w_publish) begin
        r_seq <= r_seq + 8'd1;
      end

      if (w_trigger && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end else if (i_err_clr) begin
        r_overrun <= 1'b0;
      end

      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (i_err_clr) begin
        r_timeout_err <= 1'b0;
      end

      r_rd_valid <= i_rd_req;
      if (i_rd_req) begin
        r_rd_data <= r_bank[i_rd_addr];
      end
    end
  end

  assign o_adc_sync    = r_sync;
  assign o_busy        = (r_state != StIdle);
  assign o_frame_done  = r_frame_done;
  assign o_seq         = r_seq;
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_timeout_err;
  assign o_rd_valid    = r_rd_valid;
  assign o_rd_data     = r_rd_data;

endmodule

// File: tb/tb_adc_scan_sched.sv
// Self-checking bench for adc_scan_sched: behavioural engine model plus a read
// scoreboard that is filled at request time and drained on rd_valid.
`timescale 1ns/1ps
module tb_adc_scan_sched;

  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned TIMEOUT  = 4096;
  localparam int unsigned GUARD    = 8;

  typedef struct packed {
    logic [2:0]  addr;
    logic [11:0] data;
  } rd_exp_t;

  logic                clk = 1'b0;
  logic                rst_l = 1'b0;
  logic                enable = 1'b0;
  logic                single = 1'b0;
  logic [PERIOD_W-1:0] period = '0;
  logic [7:0]          ch_mask = '0;
  logic [1:0]          avg_log2 = '0;
  logic                err_clr = 1'b0;
  logic                adc_sync;
  logic                adc_rd_en = 1'b0;
  logic [2:0]          adc_channel = '0;
  logic [11:0]         adc_data = '0;
  logic                rd_req = 1'b0;
  logic [2:0]          rd_addr = '0;
  logic                rd_valid;
  logic [11:0]         rd_data;
  logic                busy;
  logic                frame_done;
  logic [7:0]          seq;
  logic                overrun;
  logic                timeout_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int sync_cnt = 0;
  int done_cnt = 0;

  logic [11:0] eng_base [8];
  logic [11:0] exp_bank [8];
  rd_exp_t     exp_rd_q [$];
  int          eng_gap        = 3;
  int          eng_stop_after = 7;
  bit          eng_inc        = 1'b1;
  int          eng_scan       = 0;
  bit          eng_active     = 1'b0;
  int          eng_ch7_cyc    = -1;

  adc_scan_sched #(
    .PERIOD_W (PERIOD_W),
    .TIMEOUT  (TIMEOUT),
    .GUARD    (GUARD)
  ) dut (
    .i_clk         (clk),
    .i_rst_l       (rst_l),
    .i_enable      (enable),
    .i_single      (single),
    .i_period      (period),
    .i_ch_mask     (ch_mask),
    .i_avg_log2    (avg_log2),
    .i_err_clr     (err_clr),
    .o_adc_sync    (adc_sync),
    .i_adc_rd_en   (adc_rd_en),
    .i_adc_channel (adc_channel),
    .i_adc_data    (adc_data),
    .i_rd_req      (rd_req),
    .i_rd_addr     (rd_addr),
    .o_rd_valid    (rd_valid),
    .o_rd_data     (rd_data),
    .o_busy        (busy),
    .o_frame_done  (frame_done),
    .o_seq         (seq),
    .o_overrun     (overrun),
    .o_timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (adc_sync === 1'b1) sync_cnt++;
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  // Engine model: one scan per sync, strobe held two cycles per channel.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_l === 1'b1 && adc_sync === 1'b1) begin
        eng_active = 1'b1;
        for (int ch = 0; ch < 8; ch++) begin
          if (ch > eng_stop_after || rst_l !== 1'b1) break;
          repeat (eng_gap) @(posedge clk);
          #1;
          if (rst_l !== 1'b1) break;
          adc_rd_en   = 1'b1;
          adc_channel = 3'(ch);
          adc_data    = eng_base[ch] + (eng_inc ? 12'(eng_scan) : 12'd0);
          if (ch == 7) eng_ch7_cyc = cyc;
          @(posedge clk);
          @(posedge clk);
          #1;
          adc_rd_en = 1'b0;
        end
        eng_scan++;
        eng_active = 1'b0;
      end
    end
  end

  // Read scoreboard drain.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_l === 1'b1 && rd_valid === 1'b1) begin
        n_assert++;
        if (exp_rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: rd_valid with nothing pending, rd_data=%h", rd_data);
        end else begin
          e = exp_rd_q.pop_front();
          if (rd_data !== e.data) begin
            n_fail++;
            $display("FAIL rd_bank[%0d]: got %h expected %h", e.addr, rd_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic issue_read(input logic [2:0] addr);
    @(posedge clk);
    #1;
    rd_req  = 1'b1;
    rd_addr = addr;
    exp_rd_q.push_back('{addr: addr, data: exp_bank[addr]});
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_single();
    @(posedge clk);
    #1;
    single = 1'b1;
    @(posedge clk);
    #1;
    single = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [23:0] outs;
    repeat (3) @(posedge clk);
    #1;
    outs = {adc_sync, busy, frame_done, rd_valid, overrun, timeout_err, seq, rd_data};
    n_assert++;
    if (outs !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_held: outputs got %h expected 0", outs);
    end
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    outs = {adc_sync, busy, frame_done, rd_valid, overrun, timeout_err, seq, rd_data};
    n_assert++;
    if (outs !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_released: outputs got %h expected 0", outs);
    end
    for (int i = 0; i < 8; i++) exp_bank[i] = 12'd0;
    issue_read(3'd3);
    issue_read(3'd7);
  endtask

  task automatic test_single();
    int  s0;
    bit  seen;
    ch_mask  = 8'hFF;
    avg_log2 = 2'd0;
    eng_inc  = 1'b1;
    eng_scan = 0;
    for (int i = 0; i < 8; i++) eng_base[i] = 12'h100 + 12'(i);
    s0 = sync_cnt;
    pulse_single();
    n_assert++;
    if (busy !== 1'b1 || adc_sync !== 1'b0) begin
      n_fail++;
      $display("FAIL single_sync_entry: busy=%b sync=%b expected busy=1 sync=0", busy, adc_sync);
    end
    @(posedge clk);
    #1;
    n_assert++;
    if (adc_sync !== 1'b1) begin
      n_fail++;
      $display("FAIL single_sync_high: got %b expected 1", adc_sync);
    end
    @(posedge clk);
    #1;
    n_assert++;
    if (adc_sync !== 1'b0) begin
      n_fail++;
      $display("FAIL single_sync_one_cycle: got %b expected 0", adc_sync);
    end
    wait_done(400, seen);
    n_assert++;
    if (!seen) begin
      n_fail++;
      $display("FAIL single_frame_done: got none expected a pulse");
    end
    n_assert++;
    if (cyc - eng_ch7_cyc != int'(GUARD) + 3) begin
      n_fail++;
      $display("FAIL ch7_to_done_latency: got %0d expected %0d", cyc - eng_ch7_cyc, GUARD + 3);
    end
    n_assert++;
    if (seq !== 8'd1 || sync_cnt - s0 != 1) begin
      n_fail++;
      $display("FAIL single_seq_sync: seq=%0d syncs=%0d expected seq=1 syncs=1",
               seq, sync_cnt - s0);
    end
    for (int i = 0; i < 8; i++) exp_bank[i] = 12'h100 + 12'(i);
    for (int i = 0; i < 8; i++) issue_read(3'(i));
  endtask

  task automatic test_avg4();
    int          s0;
    logic [7:0]  q0;
    bit          seen;
    logic [14:0] sum;
    ch_mask  = 8'h0F;
    avg_log2 = 2'd2;
    eng_inc  = 1'b1;
    eng_scan = 0;
    eng_base[0] = 12'd10;
    for (int i = 1; i < 8; i++) eng_base[i] = 12'h200 + 12'(16 * i);
    s0 = sync_cnt;
    q0 = seq;
    pulse_single();
    wait_done(1500, seen);
    n_assert++;
    if (!seen || sync_cnt - s0 != 4) begin
      n_fail++;
      $display("FAIL avg4_syncs: done=%b syncs=%0d expected done=1 syncs=4", seen, sync_cnt - s0);
    end
    n_assert++;
    if (seq !== q0 + 8'd1) begin
      n_fail++;
      $display("FAIL avg4_seq: got %0d expected %0d", seq, q0 + 8'd1);
    end
    for (int i = 0; i < 4; i++) begin
      sum = '0;
      for (int s = 0; s < 4; s++) sum = sum + 15'(eng_base[i]) + 15'(s);
      exp_bank[i] = 12'(sum >> 2);
    end
    for (int i = 0; i < 8; i++) issue_read(3'(i));
  endtask

  task automatic test_publish_read();
    bit hit;
    ch_mask  = 8'hFF;
    avg_log2 = 2'd0;
    eng_inc  = 1'b1;
    eng_scan = 0;
    eng_ch7_cyc = -1;
    for (int i = 0; i < 8; i++) eng_base[i] = 12'h400 + 12'(i);
    pulse_single();
    hit = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (eng_ch7_cyc >= 0 && cyc == eng_ch7_cyc + int'(GUARD) + 2) begin
        hit = 1'b1;
        break;
      end
    end
    n_assert++;
    if (!hit || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL publish_cycle_reached: hit=%b busy=%b expected 1 1", hit, busy);
    end
    rd_req  = 1'b1;
    rd_addr = 3'd5;
    exp_rd_q.push_back('{addr: 3'd5, data: exp_bank[5]});
    @(posedge clk);
    #1;
    n_assert++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL publish_frame_done: got %b expected 1", frame_done);
    end
    for (int i = 0; i < 8; i++) exp_bank[i] = 12'h400 + 12'(i);
    exp_rd_q.push_back('{addr: 3'd5, data: exp_bank[5]});
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overrun();
    int         d0;
    int         s0;
    bit         hit;
    bit         seen;
    logic [7:0] q0;
    ch_mask  = 8'hFF;
    avg_log2 = 2'd0;
    eng_inc  = 1'b0;
    eng_gap  = 6;
    for (int i = 0; i < 8; i++) eng_base[i] = 12'h500 + 12'(i);
    q0     = seq;
    period = 16'd50;
    enable = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (overrun === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    n_assert++;
    if (!hit) begin
      n_fail++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    d0 = done_cnt;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt - d0 >= 2) break;
    end
    n_assert++;
    if (done_cnt - d0 < 2 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_frames_continue: frames=%0d overrun=%b expected >=2 and 1",
               done_cnt - d0, overrun);
    end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (adc_sync === 1'b1) break;
    end
    enable = 1'b0;
    wait_done(400, seen);
    n_assert++;
    if (!seen) begin
      n_fail++;
      $display("FAIL disable_mid_frame: frame_done got none expected a pulse");
    end
    s0 = sync_cnt;
    repeat (200) @(posedge clk);
    #1;
    n_assert++;
    if (sync_cnt != s0 || seq == q0) begin
      n_fail++;
      $display("FAIL disabled_quiet: syncs=%0d seq=%0d expected 0 new syncs, seq moved from %0d",
               sync_cnt - s0, seq, q0);
    end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    n_assert++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b expected 0", overrun);
    end
    eng_gap = 3;
    for (int i = 0; i < 8; i++) exp_bank[i] = 12'h500 + 12'(i);
    issue_read(3'd2);
    issue_read(3'd6);
  endtask

  task automatic test_timeout();
    int         a;
    int         d0;
    bit         hit;
    logic [7:0] q0;
    ch_mask  = 8'hFF;
    avg_log2 = 2'd0;
    eng_inc  = 1'b1;
    eng_scan = 0;
    eng_stop_after = 3;
    q0 = seq;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    single = 1'b1;
    a = cyc;
    @(posedge clk);
    #1;
    single = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) + 200; i++) begin
      @(posedge clk);
      #1;
      if (timeout_err === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    n_assert++;
    if (!hit || cyc - a != int'(TIMEOUT) + 2) begin
      n_fail++;
      $display("FAIL timeout_latency: flag=%b after %0d cycles expected 1 after %0d",
               timeout_err, cyc - a, TIMEOUT + 2);
    end
    repeat (GUARD + 2) @(posedge clk);
    #1;
    n_assert++;
    if (busy !== 1'b0 || done_cnt != d0 || seq !== q0) begin
      n_fail++;
      $display("FAIL timeout_abandon: busy=%b frames=%0d seq=%0d expected 0 0 %0d",
               busy, done_cnt - d0, seq, q0);
    end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    n_assert++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b expected 0", timeout_err);
    end
    eng_stop_after = 7;
    issue_read(3'd0);
  endtask

  task automatic test_reset_mid();
    logic [23:0] outs;
    int          s0;
    bit          hit;
    bit          seen;
    ch_mask  = 8'hFF;
    avg_log2 = 2'd0;
    pulse_single();
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (adc_rd_en === 1'b1 && adc_channel === 3'd2) begin
        hit = 1'b1;
        break;
      end
    end
    n_assert++;
    if (!hit || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_collect: reached=%b busy=%b expected 1 1", hit, busy);
    end
    rst_l = 1'b0;
    #1;
    outs = {adc_sync, busy, frame_done, rd_valid, overrun, timeout_err, seq, rd_data};
    n_assert++;
    if (outs !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h expected 0", outs);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_l = 1'b1;
    for (int i = 0; i < 200 && eng_active; i++) @(posedge clk);
    for (int i = 0; i < 8; i++) exp_bank[i] = 12'd0;
    issue_read(3'd4);
    avg_log2 = 2'd1;
    eng_inc  = 1'b1;
    eng_scan = 0;
    for (int i = 0; i < 8; i++) eng_base[i] = 12'h300 + 12'(i);
    s0 = sync_cnt;
    pulse_single();
    wait_done(800, seen);
    n_assert++;
    if (!seen || sync_cnt - s0 != 2 || seq !== 8'd1) begin
      n_fail++;
      $display("FAIL post_reset_frame: done=%b syncs=%0d seq=%0d expected 1 2 1",
               seen, sync_cnt - s0, seq);
    end
    // Two scans of base and base+1 average down to base.
    for (int i = 0; i < 8; i++) exp_bank[i] = 12'h300 + 12'(i);
    for (int i = 0; i < 8; i++) issue_read(3'(i));
  endtask

  initial begin
    test_reset();
    test_single();
    test_avg4();
    test_publish_read();
    test_overrun();
    test_timeout();
    test_reset_mid();
    repeat (4) @(posedge clk);
    n_assert++;
    if (exp_rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_missing: %0d responses outstanding expected 0", exp_rd_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_scan_sched.md
# adc_scan_sched

Scan scheduler for the 8-channel serial ADC engine. It periodically or on demand issues the engine's one-cycle `sync` start pulse, captures each per-channel result strobe, and discards results from masked-off channels. It can average 1/2/4/8 scans per frame and publishes complete frames atomically into a result bank that the host reads through a registered request port. It sits between the ADC engine and the host register/CPU logic, in the same `clk` domain as the engine.

## Interface
- `PERIOD_W`, 16: width of the frame period counter.
- `TIMEOUT`, 4096: max `clk` cycles from a scan's sync to its channel-7 result.
- `GUARD`, 8: idle `clk` cycles after a scan completes before the next sync.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_l`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  periodic scanning on.
- `single`  in  1  one-cycle pulse, request one frame.
- `period`  in  PERIOD_W  clk cycles between frame starts; 0 = back-to-back.
- `ch_mask`  in  8  bit i = 1 publishes channel i.
- `avg_log2`  in  2  scans per frame = 2^avg_log2; sampled at frame start.
- `err_clr`  in  1  clears sticky `overrun` and `timeout_err`.
- `adc_sync`  out  1  start pulse to engine.
- `adc_rd_en`  in  1  engine result strobe; level, may be high several cycles.
- `adc_channel`  in  3  engine channel index, valid with `adc_rd_en`.
- `adc_data`  in  12  engine result, valid with `adc_rd_en`.
- `rd_req`  in  1  host read request.
- `rd_addr`  in  3  channel to read.
- `rd_valid`  out  1  one-cycle read response.
- `rd_data`  out  12  published result.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse on publish.
- `seq`  out  8  published-frame counter; wraps 255 -> 0.
- `overrun`  out  1  sticky: trigger arrived while busy.
- `timeout_err`  out  1  sticky: scan exceeded `TIMEOUT`.

## Operation
- Trigger = (period tick AND `enable`) OR `single`.
- Period timer counts 0..`period`, ticks on reload, and runs only while `enable`=1. Deasserting `enable` clears it.
- FSM states:
  - IDLE: on trigger, latch `ch_mask` and `avg_log2`, clear accumulators, set round=0, go SYNC.
  - SYNC: `adc_sync`=1 for exactly one cycle, go COLLECT.
  - COLLECT: a result is a rising edge of `adc_rd_en` (one registered delay). On it, add `adc_data` into accumulator[`adc_channel`] (15 bit, zero-extended). The channel-7 result goes to GUARD. The timeout counter reaching `TIMEOUT` sets `timeout_err`, abandons the frame with no publish, and goes GUARD.
  - GUARD: wait `GUARD` cycles. If round < 2^avg_log2 - 1, increment round and go SYNC; otherwise go PUBLISH. An abandoned frame goes IDLE.
  - PUBLISH: for each latched-enabled channel, bank[i] = accumulator[i] >> avg_log2. Masked-off channels keep their old value. Pulse `frame_done`, increment `seq`, go IDLE.
- A trigger in any non-IDLE state is dropped and sets `overrun`. It is not queued.
- Deasserting `enable` mid-frame lets the current frame finish and publish.
- Duplicate result for the same channel within one scan: both are accumulated; no error is raised.
- If `err_clr` and a set event occur in the same cycle, set wins.
- Host read: `rd_req` -> `rd_valid`=1 and `rd_data`=bank[`rd_addr`] next cycle. A read in the PUBLISH cycle returns the old value, because the bank update and the read are registered in the same edge.

## Timing
- Reset values: `adc_sync`, `rd_valid`, `frame_done`, `busy`, `overrun`, `timeout_err` = 0; `rd_data`, `seq`, bank, accumulators = 0; FSM = IDLE; timer = 0.
- Trigger to `adc_sync` high: 2 cycles (IDLE -> SYNC registered).
- `busy` is high from the SYNC entry cycle through the PUBLISH cycle inclusive.
- `adc_rd_en` edge to accumulator update: 2 cycles.
- Channel-7 edge of the last round to `frame_done`: `GUARD` + 3 cycles.
- Rising edges of `adc_rd_en` must be ≥ 2 cycles apart; the engine guarantees this.
- Reset mid-frame: all state clears immediately, and `adc_sync` never glitches high.

## Structure
- Package `adc_sched_pkg`: `NUM_CH`=8, `DATA_W`=12, `ACC_W`=15, FSM state encoding (IDLE, SYNC, COLLECT, GUARD, PUBLISH).
- Sub-module `adc_period_timer`: reload counter with `enable`, `period`, and a `tick` output.
- The accumulators and the result bank stay in the top level.

## Test plan
- Reset, `single` with mask 8'hFF, avg 0, engine model returning 12'h100+i per channel i -> one `adc_sync`; `frame_done`; bank[i] = 12'h100+i; `seq`=1.
- Mask 8'h0F, avg 2 (4 scans), channel 0 data 10, 11, 12, 13 -> four syncs; bank[0] = 11; bank[4..7] unchanged.
- `enable`=1, `period`=50, engine scan longer than 50 cycles -> `overrun`=1; `err_clr` clears it; frames continue to publish.
- Engine model stalls after channel 3 -> `timeout_err` after `TIMEOUT` cycles; no `frame_done`; FSM back to IDLE.
- `rd_req` with `rd_addr`=5 in the PUBLISH cycle -> old value; the same read one cycle later -> new value.
- Assert `rst_l` low during COLLECT -> all outputs 0 at once; after release, `single` runs a clean frame.
